tree_node_dispatcher: RTL and testbench

Single-entry dispatch stage that sits directly upstream of a tree node and feeds its five child instances over independent valid/ready channels. Each accepted input word is routed to one child (unicast) or to all children (broadcast), and is held until every addressed child has taken it. Invalid destinations are discarded and counted.

---
 rtl/tree_node_dispatcher.sv | 90 +++++++++
 tb/tb_tree_node_dispatcher.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tree_node_dispatcher.sv
// Single-entry dispatch stage feeding NUM_CHILD children over valid/ready channels.
// Words are unicast or broadcast and held until every addressed child has taken them.
module tree_node_dispatcher #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CHILD = 5,
  parameter int unsigned DEST_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [DEST_W-1:0]    in_dest,
  input  logic                 in_bcast,
  output logic [NUM_CHILD-1:0] out_valid,
  input  logic [NUM_CHILD-1:0] out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy,
  output logic                 drop_err,
  output logic [7:0]           drop_count
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 hold_valid, hold_valid_n;
  logic [DATA_W-1:0]    hold_data, hold_data_n;
  logic [NUM_CHILD-1:0] pending, pending_n;
  logic                 drop_err_n;
  logic [CNT_W-1:0]     drop_count_r, drop_count_n;

  logic done_c;
  logic accept_c;
  logic dest_ok_c;

  // done: every child still owed the word takes it this cycle
  assign done_c    = hold_valid && ((pending & ~out_ready) == '0);
  assign in_ready  = !hold_valid || done_c;
  assign accept_c  = in_valid && in_ready;
  assign dest_ok_c = in_bcast || (32'(in_dest) < NUM_CHILD);

  assign out_valid  = hold_valid ? pending : '0;
  assign out_data   = hold_data;
  assign busy       = hold_valid;
  assign drop_count = drop_count_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      pending      <= '0;
      drop_err     <= 1'b0;
      drop_count_r <= '0;
    end else begin
      hold_valid   <= hold_valid_n;
      hold_data    <= hold_data_n;
      pending      <= pending_n;
      drop_err     <= drop_err_n;
      drop_count_r <= drop_count_n;
    end
  end

  // Next state: retire taken children, then let a new word replace the old one
  always_comb begin
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    pending_n    = hold_valid ? (pending & ~out_ready) : '0;
    drop_err_n   = 1'b0;
    drop_count_n = drop_count_r;

    if (done_c) begin
      hold_valid_n = 1'b0;
      pending_n    = '0;
    end

    if (accept_c) begin
      if (dest_ok_c) begin
        hold_valid_n = 1'b1;
        hold_data_n  = in_data;
        pending_n    = in_bcast ? '1 : (NUM_CHILD'(1) << in_dest);
      end else begin
        drop_err_n = 1'b1;
        if (drop_count_r != CNT_MAX) begin
          drop_count_n = drop_count_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tree_node_dispatcher.sv
// Directed self-checking bench for tree_node_dispatcher.
// Inputs change and outputs are sampled just after each falling edge.
module tb_tree_node_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_bcast;
  logic [4:0] out_valid;
  logic [4:0] out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       drop_err;
  logic [7:0] drop_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tree_node_dispatcher #(
    .DATA_W(8), .NUM_CHILD(5), .DEST_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drop_err(drop_err), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (fail #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  // advance to the next falling edge, then settle
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_dest = 3'd2;
    in_bcast = 1'b0; out_ready = 5'b00000;

    // reset held two edges with in_valid high
    repeat (2) cyc();
    rst_n = 1'b1; in_valid = 1'b0; #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_drop_err", 32'(drop_err), 32'h0);

    // unicast streaming to child 2
    cyc(); in_valid = 1'b1; in_dest = 3'd2; in_data = 8'h11; out_ready = 5'b11111; #1;
    check("uni_in_ready0", 32'(in_ready), 32'h1);
    cyc(); in_data = 8'h22; #1;
    check("uni_valid1", 32'(out_valid), 32'h04);
    check("uni_data1", 32'(out_data), 32'h11);
    check("uni_in_ready1", 32'(in_ready), 32'h1);
    cyc(); in_data = 8'h33; #1;
    check("uni_valid2", 32'(out_valid), 32'h04);
    check("uni_data2", 32'(out_data), 32'h22);
    check("uni_in_ready2", 32'(in_ready), 32'h1);
    cyc(); in_valid = 1'b0; #1;
    check("uni_valid3", 32'(out_valid), 32'h04);
    check("uni_data3", 32'(out_data), 32'h33);
    cyc();
    check("uni_idle", 32'(out_valid), 32'h0);
    check("uni_busy", 32'(busy), 32'h0);

    // broadcast with staggered ready
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hA5; out_ready = 5'b00000;
    cyc(); in_valid = 1'b0; in_bcast = 1'b0; out_ready = 5'b00011; #1;
    check("bc_valid0", 32'(out_valid), 32'h1F);
    check("bc_data0", 32'(out_data), 32'hA5);
    check("bc_in_ready0", 32'(in_ready), 32'h0);
    cyc(); out_ready = 5'b01100; #1;
    check("bc_valid1", 32'(out_valid), 32'h1C);
    check("bc_data1", 32'(out_data), 32'hA5);
    check("bc_in_ready1", 32'(in_ready), 32'h0);
    cyc(); out_ready = 5'b10000; #1;
    check("bc_valid2", 32'(out_valid), 32'h10);
    check("bc_data2", 32'(out_data), 32'hA5);
    check("bc_in_ready2", 32'(in_ready), 32'h1);
    cyc(); out_ready = 5'b00000; #1;
    check("bc_valid3", 32'(out_valid), 32'h0);

    // drops to 5 and 7, then a legal word to 3
    in_valid = 1'b1; in_dest = 3'd5; in_data = 8'h55; out_ready = 5'b11111; #1;
    check("drop_in_ready", 32'(in_ready), 32'h1);
    cyc(); in_dest = 3'd7; in_data = 8'h77; #1;
    check("drop_err1", 32'(drop_err), 32'h1);
    check("drop_cnt1", 32'(drop_count), 32'h1);
    check("drop_busy1", 32'(busy), 32'h0);
    cyc(); in_dest = 3'd3; in_data = 8'h3C; #1;
    check("drop_err2", 32'(drop_err), 32'h1);
    check("drop_cnt2", 32'(drop_count), 32'h2);
    cyc(); in_valid = 1'b0; #1;
    check("drop_err3", 32'(drop_err), 32'h0);
    check("drop_valid3", 32'(out_valid), 32'h08);
    check("drop_data3", 32'(out_data), 32'h3C);
    check("drop_cnt3", 32'(drop_count), 32'h2);
    cyc();
    check("drop_idle", 32'(out_valid), 32'h0);

    // saturation: 300 further drops
    in_valid = 1'b1; in_dest = 3'd6;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 251) check("sat_cnt254", 32'(drop_count), 32'd254);
    end
    check("sat_cnt", 32'(drop_count), 32'd255);
    check("sat_err", 32'(drop_err), 32'h1);
    in_valid = 1'b0;
    cyc();
    check("sat_err_off", 32'(drop_err), 32'h0);
    check("sat_cnt_hold", 32'(drop_count), 32'd255);

    // backpressure on child 0 while a second word waits
    in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h5A; out_ready = 5'b00000;
    cyc(); in_dest = 3'd1; in_data = 8'h99; #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(out_valid), 32'h01);
      check("bp_data", 32'(out_data), 32'h5A);
      check("bp_in_ready", 32'(in_ready), 32'h0);
      cyc();
    end
    out_ready = 5'b11111; #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    check("bp_release_valid", 32'(out_valid), 32'h01);
    cyc(); in_valid = 1'b0; #1;
    check("bp_next_valid", 32'(out_valid), 32'h02);
    check("bp_next_data", 32'(out_data), 32'h99);
    cyc();
    check("bp_idle", 32'(out_valid), 32'h0);

    // mid-operation reset during a broadcast
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hFF; out_ready = 5'b00000;
    cyc(); in_valid = 1'b0; in_bcast = 1'b0; out_ready = 5'b00011; #1;
    check("mr_valid0", 32'(out_valid), 32'h1F);
    cyc(); out_ready = 5'b00000; rst_n = 1'b0; #1;
    check("mr_valid1", 32'(out_valid), 32'h1C);
    cyc();
    check("mr_rst_valid", 32'(out_valid), 32'h0);
    check("mr_rst_busy", 32'(busy), 32'h0);
    check("mr_rst_cnt", 32'(drop_count), 32'h0);
    check("mr_rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1; out_ready = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mr_post_valid", 32'(out_valid), 32'h0);
      check("mr_post_busy", 32'(busy), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
